dmem_sram_axi_bridge: RTL and testbench
=======================================

Name: dmem_sram_axi_bridge

Overview:
- Responder for the datapath's M-stage data-memory interface: accepts one SRAM-like request (address, byte selects, store data, size) and performs it as a single-beat AXI3/AXI4 master transaction.
- Holds the pipeline through `stallreq_mem` until the transaction completes, then presents load data until the pipeline advances.
- Sits between the datapath's memory-access stage and the AXI crossbar.

Parameters:
- AXI_ID, 4'd1, ID driven on arid/awid/wid.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en  in  1  M-stage request valid.
- mem_wen  in  4  byte write selects; 0 = load.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_size  in  2  0 = byte, 1 = half, 2 = word.
- pipe_stall  in  1  pipeline frozen this cycle for any reason (OR of all stall requests).
- mem_rdata  out  32  load data.
- stallreq_mem  out  1  stall request to hazard unit.
- arid  out  4.  araddr  out  ADDR_W.  arlen  out  8 (=0).  arsize  out  3.  arburst  out  2 (=2'b01).  arvalid  out  1.  arready  in  1.
- rid  in  4.  rdata  in  32.  rresp  in  2.  rlast  in  1.  rvalid  in  1.  rready  out  1.
- awid  out  4.  awaddr  out  ADDR_W.  awlen  out  8 (=0).  awsize  out  3.  awburst  out  2 (=2'b01).  awvalid  out  1.  awready  in  1.
- wid  out  4.  wdata  out  32.  wstrb  out  4.  wlast  out  1 (=1).  wvalid  out  1.  wready  in  1.
- bid  in  4.  bresp  in  2.  bvalid  in  1.  bready  out  1.

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Reset (rst=0, async): state IDLE; all valid/ready outputs 0; mem_rdata 0; latched addr/wdata/strb/size 0; aw_done and w_done flags 0.
- `stallreq_mem` = mem_en & (state != DONE), combinational. It asserts in the same cycle a request first appears.
- IDLE:
  - mem_en & wen==0: latch addr/size → RADDR.
  - mem_en & wen!=0: latch addr/size/wdata/wen → WREQ.
  - Otherwise stay in IDLE.
- RADDR:
  - arvalid=1 with latched fields; arsize={1'b0,size}.
  - arready → RDATA.
  - arvalid holds until the handshake; no field changes while valid.
- RDATA:
  - rready=1.
  - rvalid: capture rdata into mem_rdata → DONE.
  - rresp and rid are ignored.
- WREQ:
  - awvalid = ~aw_done; wvalid = ~w_done. Both channels are issued in the same cycle.
  - Each handshake sets its flag.
  - Both complete (including the same cycle) → WRESP; flags cleared.
  - AW and W may complete in either order.
- WRESP:
  - bready=1.
  - bvalid → DONE.
  - bresp is ignored; mem_rdata is unchanged.
- DONE:
  - stallreq_mem=0; mem_rdata held.
  - ~pipe_stall → IDLE. The request retires this cycle, so it is never reissued while the M stage is held by another stall (e.g. fetch miss).
- Latency, zero-wait slave:
  - Load: request cycle (IDLE) → RADDR → RDATA → DONE gives 3 stall cycles.
  - Store: IDLE → WREQ → WRESP → DONE gives 3 stall cycles.
- A mem_en drop while in a non-IDLE state does not abort the transaction; it completes and returns to IDLE via DONE.
- Reset mid-transaction abandons it immediately. The crossbar is reset by the same rst.
- One outstanding transaction at most; read and write never overlap.

Test Plan:
- Load, zero-wait slave: mem_en=1, wen=0, addr=0x1FC0_0010, size=2; slave returns 0xDEADBEEF.
  → araddr=0x1FC0_0010, arsize=3'b010; stallreq_mem high 3 cycles; mem_rdata=0xDEADBEEF; exactly one AR handshake.
- Byte store: wen=4'b0100, addr=0x8000_0002, wdata=0x00AB_0000, size=0.
  → awsize=0, wstrb=4'b0100, wdata=0x00AB_0000, wlast=1; stall drops after the bvalid cycle.
- Split write handshake: awready delayed 3 cycles, wready immediate.
  → wvalid drops after 1 cycle; awvalid held until accepted; single B wait; no duplicate W beat.
- External stall: load completes while pipe_stall=1 for 4 more cycles.
  → state stays DONE; stallreq_mem=0; mem_rdata stable; no second AR; IDLE on the first cycle pipe_stall=0.
- Back-to-back: load then store in consecutive M cycles with pipe_stall low.
  → AR then AW/W with no overlap; stall reasserts on the cycle the store appears.
- Reset mid-RDATA: rst=0 while rready=1.
  → all valid/ready outputs 0 and mem_rdata=0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/dmem_sram_axi_bridge.sv
// dmem_sram_axi_bridge
// Converts one M-stage SRAM-style data-memory request into a single-beat
// AXI master transaction. The pipeline is held through stallreq_mem until
// the transaction finishes. Load data is then held until the pipeline advances.
//
// Handshake rule on every AXI channel: a beat transfers on a rising clk edge
// where valid and ready are both 1. A valid output, once raised, stays high
// and its payload stays constant until that edge. Ready outputs are raised
// only in the state that waits for the matching response.
module dmem_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // M-stage request side
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [1:0]        mem_size,
  input  logic              pipe_stall,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_mem,
  // AXI read address
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [3:0]        wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // Debug view of the FSM state (encoding of state_t)
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_strb;
  logic [1:0]          r_size;
  logic [31:0]         r_rdata;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_aw_done;
  logic                r_w_done;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_all;
  logic                w_w_all;
  logic                w_unused;

  // Channel handshakes and "this channel is finished" terms for the write state
  assign w_aw_hs  = r_awvalid & awready;
  assign w_w_hs   = r_wvalid & wready;
  assign w_aw_all = r_aw_done | w_aw_hs;
  assign w_w_all  = r_w_done | w_w_hs;

  // Response IDs, responses and rlast do not influence this single-beat master
  assign w_unused = ^{rid, rresp, rlast, bid, bresp};

  // Stall is combinational so it covers the very cycle the request appears
  assign stallreq_mem = mem_en & (r_state != S_DONE);

  assign mem_rdata = r_rdata;
  assign dbg_state = r_state;

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, r_size};
  assign awburst = 2'b01;
  assign awvalid = r_awvalid;

  assign wid     = AXI_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_strb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  // Transaction FSM: latches the request, drives registered valid/ready, retires in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_size    <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_en) begin
            r_addr <= mem_addr;
            r_size <= mem_size;
            if (mem_wen == 4'b0000) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end else begin
              r_wdata   <= mem_wdata;
              r_strb    <= mem_wen;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WREQ;
            end
          end
        end

        S_RADDR: begin
          if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (rvalid) begin
            r_rdata  <= rdata;
            r_rready <= 1'b0;
            r_state  <= S_DONE;
          end
        end

        S_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Both channels finished (possibly on this same edge): clear flags for next store
          if (w_aw_all && w_w_all) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          // Retire only when the pipeline moves, so a held M stage never reissues
          if (!pipe_stall) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_axi_bridge.sv
// tb_dmem_sram_axi_bridge
// Directed bench for the data-memory AXI bridge. The AXI slave side is driven
// step by step from one initial block. Small monitors count handshakes and
// stall cycles so that totals can be compared against hand-derived numbers.
module tb_dmem_sram_axi_bridge;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WREQ  = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int ar_cnt = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cnt  = 0;
  int stall_cnt = 0;

  dmem_sram_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .pipe_stall(pipe_stall),
    .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and stall-cycle monitors, sampled on the active edge
  always @(posedge clk) begin
    if (rst) begin
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
      if (bvalid && bready)   b_cnt  <= b_cnt + 1;
      if (stallreq_mem)       stall_cnt <= stall_cnt + 1;
    end
  end

  // Advance one clock; inputs change and outputs are sampled 2 units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int s_ar, s_aw, s_w, s_b, s_st;
  logic [31:0] held;

  initial begin
    // Clock/reset block
    rst = 1'b0; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0;
    mem_wdata = 32'h0; mem_size = 2'd0; pipe_stall = 1'b0;
    arready = 1'b0; rid = 4'd1; rdata = 32'h0; rresp = 2'd0; rlast = 1'b1;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0;
    bvalid = 1'b0;
    tick(); tick();
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_stall", {31'd0, stallreq_mem}, 32'd0);
    rst = 1'b1;
    tick();

    // ---- Load, zero-wait slave ----
    s_ar = ar_cnt; s_st = stall_cnt;
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h1FC0_0010; mem_size = 2'd2;
    arready = 1'b1;
    #1;
    chk("ld_stall_same_cycle", {31'd0, stallreq_mem}, 32'd1);
    tick();
    chk("ld_raddr_state", {29'd0, dbg_state}, {29'd0, ST_RADDR});
    chk("ld_arvalid", {31'd0, arvalid}, 32'd1);
    chk("ld_araddr", araddr, 32'h1FC0_0010);
    chk("ld_arsize", {29'd0, arsize}, 32'd2);
    chk("ld_ar_fixed", {16'd0, arid, arlen, arburst, 2'd0}, {16'd0, 4'd1, 8'd0, 2'b01, 2'd0});
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    chk("ld_rready", {31'd0, rready}, 32'd1);
    chk("ld_arvalid_drop", {31'd0, arvalid}, 32'd0);
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    chk("ld_done_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
    chk("ld_done_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_stall_cycles", stall_cnt - s_st, 32'd3);
    mem_en = 1'b0;
    tick();
    chk("ld_ar_once", ar_cnt - s_ar, 32'd1);
    chk("ld_back_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // ---- Byte store ----
    s_st = stall_cnt; s_b = b_cnt;
    mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h8000_0002;
    mem_wdata = 32'h00AB_0000; mem_size = 2'd0;
    awready = 1'b1; wready = 1'b1;
    tick();
    chk("st_wreq_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("st_awaddr", awaddr, 32'h8000_0002);
    chk("st_awsize", {29'd0, awsize}, 32'd0);
    chk("st_wstrb", {28'd0, wstrb}, 32'h4);
    chk("st_wdata", wdata, 32'h00AB_0000);
    chk("st_wlast", {31'd0, wlast}, 32'd1);
    bvalid = 1'b1;
    tick();
    chk("st_wresp_state", {29'd0, dbg_state}, {29'd0, ST_WRESP});
    chk("st_bready", {31'd0, bready}, 32'd1);
    chk("st_wresp_stall", {31'd0, stallreq_mem}, 32'd1);
    tick();
    bvalid = 1'b0;
    chk("st_done_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("st_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    chk("st_stall_cycles", stall_cnt - s_st, 32'd3);
    mem_en = 1'b0;
    tick();
    chk("st_b_once", b_cnt - s_b, 32'd1);

    // ---- Split write handshake: AW late, W immediate ----
    s_aw = aw_cnt; s_w = w_cnt; s_b = b_cnt;
    mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h0000_0100;
    mem_wdata = 32'h1234_5678; mem_size = 2'd2;
    awready = 1'b0; wready = 1'b1;
    tick();
    chk("sp_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    chk("sp_c2_valids", {30'd0, awvalid, wvalid}, 32'd2);
    tick();
    chk("sp_c3_valids", {30'd0, awvalid, wvalid}, 32'd2);
    chk("sp_c3_state", {29'd0, dbg_state}, {29'd0, ST_WREQ});
    awready = 1'b1;
    tick();
    chk("sp_wresp_state", {29'd0, dbg_state}, {29'd0, ST_WRESP});
    chk("sp_w_once", w_cnt - s_w, 32'd1);
    chk("sp_aw_once", aw_cnt - s_aw, 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("sp_done_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
    mem_en = 1'b0;
    tick();
    chk("sp_b_once", b_cnt - s_b, 32'd1);

    // ---- External stall holds DONE ----
    s_ar = ar_cnt;
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h0000_2000; mem_size = 2'd1;
    pipe_stall = 1'b1; arready = 1'b1;
    tick();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    held = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      chk("ex_done_state", {29'd0, dbg_state}, {29'd0, ST_DONE});
      chk("ex_no_stall", {31'd0, stallreq_mem}, 32'd0);
      chk("ex_rdata_stable", mem_rdata, held);
      tick();
    end
    chk("ex_ar_once", ar_cnt - s_ar, 32'd1);
    pipe_stall = 1'b0; mem_en = 1'b0;
    tick();
    chk("ex_idle_first", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // ---- Back-to-back load then store ----
    s_ar = ar_cnt; s_aw = aw_cnt;
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h0000_3000; mem_size = 2'd2;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    tick();
    chk("bb_raddr_no_aw", {30'd0, arvalid, awvalid}, 32'd2);
    rvalid = 1'b1; rdata = 32'h5555_AAAA;
    tick();
    tick();
    rvalid = 1'b0;
    chk("bb_ld_done", {29'd0, dbg_state}, {29'd0, ST_DONE});
    tick();
    mem_wen = 4'b0011; mem_addr = 32'h0000_3004; mem_wdata = 32'h0000_BEEF;
    mem_size = 2'd1;
    #1;
    chk("bb_st_stall_again", {31'd0, stallreq_mem}, 32'd1);
    tick();
    chk("bb_wreq_no_ar", {29'd0, arvalid, awvalid, wvalid}, 32'd3);
    chk("bb_wstrb", {28'd0, wstrb}, 32'h3);
    chk("bb_ar_once", ar_cnt - s_ar, 32'd1);
    bvalid = 1'b1;
    tick();
    tick();
    bvalid = 1'b0;
    chk("bb_st_done", {29'd0, dbg_state}, {29'd0, ST_DONE});
    chk("bb_rdata", mem_rdata, 32'h5555_AAAA);
    chk("bb_aw_once", aw_cnt - s_aw, 32'd1);
    mem_en = 1'b0;
    tick();

    // ---- Reset in the middle of RDATA ----
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h0000_4000; mem_size = 2'd2;
    arready = 1'b1; rvalid = 1'b0;
    tick();
    tick();
    chk("rr_rready", {31'd0, rready}, 32'd1);
    rst = 1'b0; mem_en = 1'b0;
    #1;
    chk("rr_async_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rr_async_rdata", mem_rdata, 32'h0);
    chk("rr_async_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    tick();
    rst = 1'b1;
    tick();
    chk("rr_idle_after", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rr_idle_stall", {31'd0, stallreq_mem}, 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
